seg7_scan_driver: RTL

Time-multiplexed driver for the 4-digit common-select 7-segment display. It latches a 16-bit hex value and scans one digit per slot, with a dead-time gap at the start of each slot to prevent ghosting. It drives the digit nibble into decoder7seg and drives the active-low digit-select lines and decimal point directly. It sits directly upstream of decoder7seg and replaces the static switch-driven line select.

---
 rtl/seg7_pkg.sv | 11 +
 rtl/seg7_slot_timer.sv | 61 ++++++
 rtl/seg7_scan_driver.sv | 84 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment driver.
package seg7_pkg;
    localparam int         NUM_DIGITS   = 4;
    localparam logic [3:0] LINE_ALL_OFF = 4'b1111;
    localparam logic       DP_OFF       = 1'b1;

    typedef enum logic {
        PH_GAP = 1'b0,
        PH_ON  = 1'b1
    } phase_t;
endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timing for the digit scan: counter, digit index, GAP/ON phase and frame pulse.
// Exposes the state of the upcoming cycle so the top can register its outputs in step.
module seg7_slot_timer
    import seg7_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int GAP_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] idx_next,
    output phase_t     phase_next,
    output logic       boundary,
    output logic       frame_done
);
    localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_GAP  = CW'(GAP_CYCLES);
    localparam logic [1:0]    IDX_LAST = 2'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    idx_reg;
    phase_t        phase_reg;
    logic          frame_done_reg, frame_done_next;
    logic          wrap;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            phase_reg      <= PH_GAP;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            phase_reg      <= phase_next;
            frame_done_reg <= frame_done_next;
        end
    end

    // Next-state logic
    always_comb begin
        wrap       = (cnt_reg == CNT_MAX);
        cnt_next   = wrap ? '0 : cnt_reg + 1'b1;
        idx_next   = wrap ? idx_reg + 2'd1 : idx_reg;
        phase_next = phase_reg;
        case (phase_reg)
            PH_GAP:  if (cnt_next == CNT_GAP) phase_next = PH_ON;
            PH_ON:   if (cnt_next == '0)      phase_next = PH_GAP;
            default: phase_next = PH_GAP;
        endcase
        frame_done_next = (idx_next == IDX_LAST) && (cnt_next == CNT_MAX);
    end

    // Outputs: boundary marks the current cycle as the last of the frame
    always_comb begin
        boundary   = wrap && (idx_reg == IDX_LAST);
        frame_done = frame_done_reg;
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with per-slot dead time, leading-zero
// blanking and frame-synchronised value updates. All outputs are registered.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int TICK_DIV   = 50000,
    parameter int GAP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        lz_blank,
    input  logic [3:0]  dp_in,
    output logic [3:0]  data,
    output logic [3:0]  line,
    output logic        dp,
    output logic        frame_done
);
    logic [15:0] active_reg, active_next;
    logic [15:0] pending_reg;
    logic        pend_flag_reg;
    logic [3:0]  data_reg, line_reg;
    logic        dp_reg;

    logic [1:0]  idx_next;
    phase_t      phase_next;
    logic        boundary;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic        blank, lit;

    seg7_slot_timer #(
        .TICK_DIV   (TICK_DIV),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .idx_next   (idx_next),
        .phase_next (phase_next),
        .boundary   (boundary),
        .frame_done (frame_done)
    );

    // upper_zero[i]: digits i..3 of the value being shown next cycle are all zero
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper
            assign upper_zero[gi] = ~|active_next[15:4*gi];
        end
    endgenerate

    always_comb begin
        active_next = (boundary && pend_flag_reg) ? pending_reg : active_reg;
        blank       = lz_blank && (idx_next != 2'd0) && upper_zero[idx_next];
        lit         = (phase_next == PH_ON) && !blank;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_reg    <= '0;
            pending_reg   <= '0;
            pend_flag_reg <= 1'b0;
            data_reg      <= '0;
            line_reg      <= LINE_ALL_OFF;
            dp_reg        <= DP_OFF;
        end else begin
            active_reg <= active_next;
            // A load on the boundary cycle lands in pending and waits a full frame
            if (load) begin
                pending_reg   <= value;
                pend_flag_reg <= 1'b1;
            end else if (boundary) begin
                pend_flag_reg <= 1'b0;
            end
            data_reg <= active_next[4*idx_next +: 4];
            line_reg <= lit ? ~(4'b0001 << idx_next) : LINE_ALL_OFF;
            dp_reg   <= lit ? ~dp_in[idx_next] : DP_OFF;
        end
    end

    assign data = data_reg;
    assign line = line_reg;
    assign dp   = dp_reg;
endmodule
